// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter sharing one 32-bit ALU, with a single registered result slot.
// Optional ALU_ARB_CONFLICT_CNT_EN adds a saturating count of contended cycles on conflict_cnt.

module alu (
  input  logic [3:0]  sel_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  // sel = {extra_bit, funct3}; extra_bit selects SUB, SRA, and pass-b (LUI) on AND's slot
  always_comb begin
    y_o = '0;
    case (sel_i[2:0])
      3'b000: y_o = sel_i[3] ? (a_i - b_i) : (a_i + b_i);
      3'b001: y_o = a_i << b_i[4:0];
      3'b010: y_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      3'b011: y_o = {31'b0, (a_i < b_i)};
      3'b100: y_o = a_i ^ b_i;
      3'b101: y_o = sel_i[3] ? 32'($signed(a_i) >>> b_i[4:0]) : (a_i >> b_i[4:0]);
      3'b110: y_o = a_i | b_i;
      3'b111: y_o = sel_i[3] ? b_i : (a_i & b_i);
      default: y_o = '0;
    endcase
  end

endmodule

module alu_share_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_sel,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_sel,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag
`ifdef ALU_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]      conflict_cnt
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL0 = 2'd1,
    S_FULL1 = 2'd2
  } slot_e;

  slot_e            state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [XLEN-1:0]  data0_q, data0_d, data1_q, data1_d;
  logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic             free, grant0, grant1;
  logic [3:0]       alu_sel;
  logic [XLEN-1:0]  alu_a, alu_b, alu_y;

  // Ungranted cycles still present requester 0 to the ALU; the result is simply not captured
  assign alu_sel = grant1 ? req1_sel : req0_sel;
  assign alu_a   = grant1 ? req1_a   : req0_a;
  assign alu_b   = grant1 ? req1_b   : req0_b;

  alu u_alu (
    .sel_i (alu_sel),
    .a_i   (alu_a),
    .b_i   (alu_b),
    .y_o   (alu_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      ptr_q   <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data0_d = data0_q;
    data1_d = data1_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
    grant0  = 1'b0;
    grant1  = 1'b0;

    // Slot can take a new result if empty or if the held result drains this cycle
    case (state_q)
      S_EMPTY: free = 1'b1;
      S_FULL0: free = rsp0_ready;
      S_FULL1: free = rsp1_ready;
      default: free = 1'b1;
    endcase

    if (free) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~ptr_q;
        grant1 = ptr_q;
        ptr_d  = ~ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end

    if (grant0) begin
      state_d = S_FULL0;
      data0_d = alu_y;
      tag0_d  = req0_tag;
    end else if (grant1) begin
      state_d = S_FULL1;
      data1_d = alu_y;
      tag1_d  = req1_tag;
    end else if (free) begin
      state_d = S_EMPTY;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state_q == S_FULL0);
  assign rsp1_valid = (state_q == S_FULL1);
  assign rsp0_data  = data0_q;
  assign rsp1_data  = data1_q;
  assign rsp0_tag   = tag0_q;
  assign rsp1_tag   = tag1_q;

`ifdef ALU_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Contended cycle: both asked and one lost
  always_comb begin
    cnt_d = cnt_q;
    if (req0_valid && req1_valid && (grant0 || grant1) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level reference model.
// Checks conflict_cnt too when ALU_ARB_CONFLICT_CNT_EN is defined.

module tb_alu_share_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]       req0_sel, req1_sel;
  logic [XLEN-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [XLEN-1:0]  rsp0_data, rsp1_data;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
`ifdef ALU_ARB_CONFLICT_CNT_EN
  logic [15:0]      conflict_cnt;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_tag   (rsp0_tag),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_tag   (rsp1_tag)
`ifdef ALU_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner of the held result (-1 = none), per-port last data/tag, preferred port
  int          m_owner;
  logic [31:0] m_data [2];
  logic [3:0]  m_tag  [2];
  int          m_pref;
  int          m_cnt;

  logic [3:0] legal_sel [11] = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7, 4'd15};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = 32'(b % 32);
    case (sel)
      4'd0:    r = a + b;
      4'd8:    r = a - b;
      4'd1:    r = a << sh;
      4'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    r = (a < b) ? 32'd1 : 32'd0;
      4'd4:    r = a ^ b;
      4'd5:    r = a >> sh;
      4'd13:   r = $signed(a) >>> sh;
      4'd6:    r = a | b;
      4'd7:    r = a & b;
      4'd15:   r = b;
      default: r = 'x;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_data  = '{32'd0, 32'd0};
    m_tag   = '{4'd0, 4'd0};
    m_pref  = 0;
    m_cnt   = 0;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
    req0_valid = v; req0_sel = s; req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
    req1_valid = v; req1_sel = s; req1_a = a; req1_b = b; req1_tag = t;
  endtask

  // One clock: compare outputs to the model, then advance the model with the same inputs
  task automatic cycle(input bit do_check);
    bit drains;
    int win;
    #1;
    drains = (m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready);
    win = -1;
    if (m_owner < 0 || drains) begin
      if (req0_valid && req1_valid) win = m_pref;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    if (do_check) begin
      check("rsp0_valid", 32'(rsp0_valid), 32'(m_owner == 0));
      check("rsp1_valid", 32'(rsp1_valid), 32'(m_owner == 1));
      check("rsp0_data", rsp0_data, m_data[0]);
      check("rsp1_data", rsp1_data, m_data[1]);
      check("rsp0_tag", 32'(rsp0_tag), 32'(m_tag[0]));
      check("rsp1_tag", 32'(rsp1_tag), 32'(m_tag[1]));
      check("req0_ready", 32'(req0_ready), 32'(win == 0));
      check("req1_ready", 32'(req1_ready), 32'(win == 1));
`ifdef ALU_ARB_CONFLICT_CNT_EN
      check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`endif
    end
    @(posedge clk);
    if (req0_valid && req1_valid && win >= 0) begin
      m_pref = 1 - win;
      if (m_cnt < 65535) m_cnt++;
    end
    if (win == 0) begin
      m_owner = 0; m_data[0] = ref_alu(req0_sel, req0_a, req0_b); m_tag[0] = req0_tag;
    end else if (win == 1) begin
      m_owner = 1; m_data[1] = ref_alu(req1_sel, req1_a, req1_b); m_tag[1] = req1_tag;
    end else if (m_owner < 0 || drains) begin
      m_owner = -1;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40));
      1:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set_req0(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    repeat (2) cycle(1'b1);

    // Single ADD on requester 0
    set_req0(1'b1, 4'b0000, 32'd5, 32'd3, 4'd2);
    cycle(1'b1);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    check("single_valid", 32'(rsp0_valid), 32'd1);
    check("single_data", rsp0_data, 32'd8);
    check("single_tag", 32'(rsp0_tag), 32'd2);
    check("single_rsp1_idle", 32'(rsp1_valid), 32'd0);

    // Backpressure on the held result, then same-cycle grant to the waiting requester
    set_req1(1'b1, 4'b1101, 32'h8000_0000, 32'd4, 4'd7);
    repeat (3) cycle(1'b1);
    check("hold_data", rsp0_data, 32'd8);
    check("hold_req1_ready", 32'(req1_ready), 32'd0);
    rsp0_ready = 1'b1;
    cycle(1'b1);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    check("sra_valid", 32'(rsp1_valid), 32'd1);
    check("sra_data", rsp1_data, 32'hF800_0000);

    // Owner handover from requester 1 to requester 0 without a bubble
    rsp1_ready = 1'b1;
    set_req0(1'b1, 4'b0000, 32'd1, 32'd1, 4'd3);
    cycle(1'b1);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    check("handover_rsp1", 32'(rsp1_valid), 32'd0);
    check("handover_rsp0", 32'(rsp0_valid), 32'd1);
    check("handover_data", rsp0_data, 32'd2);

    // Sustained contention: alternating SUB and SLT results
    set_req0(1'b1, 4'b1000, 32'd10, 32'd3, 4'd1);
    set_req1(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'd9);
    repeat (8) cycle(1'b1);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    cycle(1'b1);

    // Asynchronous reset with a held requester-0 result
    rsp0_ready = 1'b0;
    set_req0(1'b1, 4'b0000, 32'd5, 32'd3, 4'd2);
    cycle(1'b1);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    check("pre_reset_valid", 32'(rsp0_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(rsp0_valid), 32'd0);
    check("async_reset_data", rsp0_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1'b1);

    // Randomized traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      set_req0(1'($urandom_range(0, 1)), legal_sel[$urandom_range(0, 10)], rand_op(), rand_op(),
               4'($urandom));
      set_req1(1'($urandom_range(0, 1)), legal_sel[$urandom_range(0, 10)], rand_op(), rand_op(),
               4'($urandom));
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      cycle(1'b1);
    end

`ifdef ALU_ARB_CONFLICT_CNT_EN
    // Saturation of the conflict counter
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req0(1'b1, 4'b0000, 32'd1, 32'd2, 4'd0);
    set_req1(1'b1, 4'b0000, 32'd3, 32'd4, 4'd1);
    for (int i = 0; i < 65540; i++) cycle(1'b0);
    check("cnt_saturated", 32'(conflict_cnt), 32'h0000_FFFF);
    repeat (3) cycle(1'b1);
    check("cnt_holds", 32'(conflict_cnt), 32'h0000_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
